hist_replay: RTL and testbench
==============================

Name: hist_replay

Overview:
- Read-side counterpart of the trial history writer.
- When a trial ends (break/reward event), it snapshots the packed multi-slot history buses (input, hippocampal and output vectors) and replays them one slot per beat, newest first, to the downstream reward/weight-update unit.
- Each beat carries the slot's age and the reward sign, so the consumer can apply eligibility-trace decay.
- Transfers use a valid/ready handshake.

Parameters:
- N_IN, 8, width of one input-layer vector (Layer1).
- N_HIP, 16, width of one hippocampal vector (Layer2).
- N_OUT, 4, width of one output-layer vector (Layer3).
- NHIST, 2, number of history slots; legal range 2..16.
- SLOT_W, 1, pointer width; must satisfy 2^SLOT_W >= NHIST.
- SKIP_EMPTY, 1, when 1, slots whose output and hippo vectors are both all-zero are not presented.

Ports:
- clk, in, 1, clock, rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, single-cycle request to begin replay.
- reward_sign, in, 1, 1 = reward, 0 = punishment; captured on start.
- newest_slot, in, SLOT_W, index of the most recently written slot; captured on start.
- in_hst, in, NHIST*N_IN, packed input history; slot k occupies bits [(k+1)*N_IN-1 : k*N_IN].
- hip_hst, in, NHIST*N_HIP, packed hippo history; same slot packing.
- out_hst, in, NHIST*N_OUT, packed output history; same slot packing.
- rd_ready, in, 1, consumer accepts the current beat.
- rd_valid, out, 1, beat valid.
- rd_in, out, N_IN, input vector of the current slot.
- rd_hip, out, N_HIP, hippo vector of the current slot.
- rd_out, out, N_OUT, output vector of the current slot.
- rd_age, out, SLOT_W, 0 = newest slot, incrementing per slot examined (skipped slots still advance age).
- rd_reward, out, 1, captured reward_sign.
- rd_last, out, 1, marks the final presented beat of this replay.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at replay completion.

Behaviour:
- Reset: state IDLE. rd_valid, rd_last, busy and done are 0. All rd_* data outputs, the snapshot registers, the age counter and the slot pointer are 0. Reset mid-replay aborts immediately; no done pulse is generated.
- States: IDLE, LOAD, SCAN, PRESENT, FINISH.
- IDLE -> LOAD: on start=1.
  - At that edge, capture in_hst, hip_hst, out_hst, newest_slot and reward_sign into snapshot registers.
  - Later input changes do not affect the replay.
  - newest_slot values >= NHIST are wrapped modulo NHIST.
- LOAD -> SCAN: unconditional. ptr = newest_slot, age = 0, remaining = NHIST.
- SCAN, current slot empty (SKIP_EMPTY=1 and both snapshot out and hip slices are all-zero):
  - Skip the slot: ptr = (ptr==0) ? NHIST-1 : ptr-1; age++; remaining--.
  - If remaining reaches 0, go to FINISH.
  - Each skip costs exactly 1 cycle.
- SCAN, current slot not empty: go to PRESENT.
  - Drive rd_in, rd_hip, rd_out from slot ptr; rd_age = age; rd_reward = captured sign.
  - rd_last = 1 if no later slot (within remaining) would be presented, evaluated over the snapshot.
  - rd_valid = 1.
- Minimum latency: start sampled at edge t gives rd_valid=1 after edge t+2 when the newest slot is non-empty.
- PRESENT: rd_valid and all rd_* outputs are held stable until rd_valid & rd_ready at an edge.
  - On handshake with rd_last=1: go to FINISH.
  - Otherwise: decrement ptr (wrapping), age++, remaining--, go to SCAN.
- rd_ready is ignored while rd_valid=0. rd_ready held high gives one beat per two cycles (PRESENT/SCAN alternation).
- FINISH: rd_valid = 0, done = 1 for exactly one cycle, then IDLE.
  - All-empty snapshot: done occurs with zero beats; latency is NHIST+2 cycles from start.
- start while busy=1 is ignored (no re-capture, no queueing). start in the FINISH cycle is also ignored.
- SKIP_EMPTY=0: every slot is presented; exactly NHIST beats per replay.
- Age and pointer arithmetic is modulo NHIST on ptr only. age never exceeds NHIST-1.

Test Plan:
1. NHIST=2, N_IN=N_HIP=4, N_OUT=2. in_hst=8'hA5, hip_hst=8'h3C, out_hst=4'b1001, newest_slot=1, rd_ready=1, start pulse -> beat0 {in=A, hip=3, out=2'b10, age=0, last=0}, beat1 {in=5, hip=C, out=2'b01, age=1, last=1}, then done pulse; rd_valid first high 2 cycles after start.
2. Same data, newest_slot=0 -> slot 0 first (in=5, age=0), then slot 1 (in=A, age=1, last=1).
3. out_hst=4'b0100, hip_hst=8'h30, SKIP_EMPTY=1, newest_slot=0 -> slot 0 skipped; single beat from slot 1 with age=1, last=1; done.
4. out_hst=0, hip_hst=0 -> no rd_valid at all; done pulse 4 cycles after start.
5. Backpressure: rd_ready=0 for 5 cycles during beat0 -> outputs held constant; input buses changed mid-replay and second start pulses are ignored; beat1 follows the delayed handshake.
6. Reset asserted while in PRESENT -> next cycle rd_valid=0, busy=0, no done; a new start then replays normally.

Source files
------------

// File: rtl/hist_replay.sv
// Replays a snapshot of the trial history buses one slot per beat, newest first,
// tagging each beat with its age and the reward sign for eligibility-trace decay.
module hist_replay #(
    parameter int N_IN       = 8,
    parameter int N_HIP      = 16,
    parameter int N_OUT      = 4,
    parameter int NHIST      = 2,
    parameter int SLOT_W     = 1,
    parameter int SKIP_EMPTY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    reward_sign,
    input  logic [SLOT_W-1:0]       newest_slot,
    input  logic [NHIST*N_IN-1:0]   in_hst,
    input  logic [NHIST*N_HIP-1:0]  hip_hst,
    input  logic [NHIST*N_OUT-1:0]  out_hst,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [N_IN-1:0]         rd_in,
    output logic [N_HIP-1:0]        rd_hip,
    output logic [N_OUT-1:0]        rd_out,
    output logic [SLOT_W-1:0]       rd_age,
    output logic                    rd_reward,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    done
);

    localparam int REM_W = $clog2(NHIST + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, PRESENT, FINISH} stateT;

    stateT                   state;
    logic [NHIST*N_IN-1:0]   snapIn;
    logic [NHIST*N_HIP-1:0]  snapHip;
    logic [NHIST*N_OUT-1:0]  snapOut;
    logic [SLOT_W-1:0]       snapNewest;
    logic                    snapReward;
    logic [SLOT_W-1:0]       ptr;
    logic [SLOT_W-1:0]       age;
    logic [REM_W-1:0]        remaining;

    logic [N_IN-1:0]         inSlot  [NHIST];
    logic [N_HIP-1:0]        hipSlot [NHIST];
    logic [N_OUT-1:0]        outSlot [NHIST];
    logic [NHIST-1:0]        slotEmpty;
    logic [SLOT_W-1:0]       wrappedNewest;
    logic [SLOT_W-1:0]       prevPtr;
    logic [SLOT_W-1:0]       scanIdx;
    logic                    laterPresent;

    for (genvar k = 0; k < NHIST; k++) begin : gSlot
        assign inSlot[k]    = snapIn[k*N_IN +: N_IN];
        assign hipSlot[k]   = snapHip[k*N_HIP +: N_HIP];
        assign outSlot[k]   = snapOut[k*N_OUT +: N_OUT];
        assign slotEmpty[k] = (SKIP_EMPTY != 0) && (outSlot[k] == '0) && (hipSlot[k] == '0);
    end

    assign wrappedNewest = SLOT_W'(int'(newest_slot) % NHIST);
    assign prevPtr       = (ptr == '0) ? SLOT_W'(NHIST - 1) : ptr - SLOT_W'(1);
    assign busy          = (state != IDLE);

    // Look ahead over the older slots still in this replay to decide rd_last.
    always_comb begin
        laterPresent = 1'b0;
        scanIdx      = '0;
        for (int i = 1; i < NHIST; i++) begin
            scanIdx = SLOT_W'((int'(ptr) + NHIST - i) % NHIST);
            if (i < int'(remaining) && !slotEmpty[scanIdx]) begin
                laterPresent = 1'b1;
            end
        end
    end

    // done is registered as FINISH retires, so it lands NHIST+2 cycles after start for an empty snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            snapIn     <= '0;
            snapHip    <= '0;
            snapOut    <= '0;
            snapNewest <= '0;
            snapReward <= 1'b0;
            ptr        <= '0;
            age        <= '0;
            remaining  <= '0;
            rd_valid   <= 1'b0;
            rd_in      <= '0;
            rd_hip     <= '0;
            rd_out     <= '0;
            rd_age     <= '0;
            rd_reward  <= 1'b0;
            rd_last    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snapIn     <= in_hst;
                        snapHip    <= hip_hst;
                        snapOut    <= out_hst;
                        snapNewest <= wrappedNewest;
                        snapReward <= reward_sign;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    ptr       <= snapNewest;
                    age       <= '0;
                    remaining <= REM_W'(NHIST);
                    state     <= SCAN;
                end
                SCAN: begin
                    if (slotEmpty[ptr]) begin
                        remaining <= remaining - REM_W'(1);
                        if (remaining == REM_W'(1)) begin
                            state <= FINISH;
                        end else begin
                            ptr <= prevPtr;
                            age <= age + SLOT_W'(1);
                        end
                    end else begin
                        rd_valid  <= 1'b1;
                        rd_in     <= inSlot[ptr];
                        rd_hip    <= hipSlot[ptr];
                        rd_out    <= outSlot[ptr];
                        rd_age    <= age;
                        rd_reward <= snapReward;
                        rd_last   <= !laterPresent;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (rd_last) begin
                            state <= FINISH;
                        end else begin
                            ptr       <= prevPtr;
                            age       <= age + SLOT_W'(1);
                            remaining <= remaining - REM_W'(1);
                            state     <= SCAN;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_replay.sv
// Directed bench for hist_replay: a queue-based model of the expected beat sequence
// is compared against the DUT every cycle, alongside hand-computed literal checks.
module tb_hist_replay;

    localparam int N_IN       = 4;
    localparam int N_HIP      = 4;
    localparam int N_OUT      = 2;
    localparam int NHIST      = 2;
    localparam int SLOT_W     = 1;
    localparam int SKIP_EMPTY = 1;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic                    reward_sign;
    logic [SLOT_W-1:0]       newest_slot;
    logic [NHIST*N_IN-1:0]   in_hst;
    logic [NHIST*N_HIP-1:0]  hip_hst;
    logic [NHIST*N_OUT-1:0]  out_hst;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [N_IN-1:0]         rd_in;
    logic [N_HIP-1:0]        rd_hip;
    logic [N_OUT-1:0]        rd_out;
    logic [SLOT_W-1:0]       rd_age;
    logic                    rd_reward;
    logic                    rd_last;
    logic                    busy;
    logic                    done;

    typedef struct packed {
        logic [N_IN-1:0]   inV;
        logic [N_HIP-1:0]  hipV;
        logic [N_OUT-1:0]  outV;
        logic [SLOT_W-1:0] age;
        logic              reward;
        logic              last;
    } beatT;

    beatT expQ[$];
    int   checks = 0;
    int   errors = 0;

    hist_replay #(
        .N_IN(N_IN), .N_HIP(N_HIP), .N_OUT(N_OUT),
        .NHIST(NHIST), .SLOT_W(SLOT_W), .SKIP_EMPTY(SKIP_EMPTY)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .reward_sign(reward_sign),
        .newest_slot(newest_slot), .in_hst(in_hst), .hip_hst(hip_hst), .out_hst(out_hst),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_in(rd_in), .rd_hip(rd_hip),
        .rd_out(rd_out), .rd_age(rd_age), .rd_reward(rd_reward), .rd_last(rd_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected beats: walk ages 0..NHIST-1 from the newest slot backwards, keep non-empty ones.
    task automatic buildModel(input int newest, input logic sign, input logic [NHIST*N_IN-1:0] inH,
                              input logic [NHIST*N_HIP-1:0] hipH, input logic [NHIST*N_OUT-1:0] outH);
        beatT tail;
        expQ.delete();
        for (int a = 0; a < NHIST; a++) begin
            int   s;
            beatT b;
            s        = ((newest % NHIST) - a + NHIST) % NHIST;
            b.inV    = N_IN'(inH >> (s * N_IN));
            b.hipV   = N_HIP'(hipH >> (s * N_HIP));
            b.outV   = N_OUT'(outH >> (s * N_OUT));
            b.age    = SLOT_W'(a);
            b.reward = sign;
            b.last   = 1'b0;
            if (SKIP_EMPTY == 0 || b.outV != '0 || b.hipV != '0) expQ.push_back(b);
        end
        if (expQ.size() > 0) begin
            tail      = expQ[expQ.size()-1];
            tail.last = 1'b1;
            expQ[expQ.size()-1] = tail;
        end
    endtask

    task automatic applyStimulus(input logic [SLOT_W-1:0] newest, input logic sign,
                                 input logic [NHIST*N_IN-1:0] inH, input logic [NHIST*N_HIP-1:0] hipH,
                                 input logic [NHIST*N_OUT-1:0] outH);
        @(negedge clk);
        in_hst      = inH;
        hip_hst     = hipH;
        out_hst     = outH;
        newest_slot = newest;
        reward_sign = sign;
        start       = 1'b1;
        buildModel(int'(newest), sign, inH, hipH, outH);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a replay to its done pulse; optional stall perturbs inputs and re-pulses start while stalled.
    task automatic runReplay(input int expFirst, input int expDone, input int stall, input int probeAt);
        int firstValid = -1;
        int doneAt     = -1;
        int stallLeft  = stall;
        rd_ready = (stall == 0);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_valid && firstValid < 0) firstValid = k;
            if (done) begin
                doneAt = k;
                break;
            end
            if (rd_valid && stallLeft > 0) begin
                stallLeft--;
                in_hst      = ~in_hst;
                hip_hst     = ~hip_hst;
                out_hst     = ~out_hst;
                newest_slot = ~newest_slot;
                reward_sign = ~reward_sign;
                start       = 1'b1;
            end else if (stallLeft == 0) begin
                rd_ready = 1'b1;
            end
            if (k == probeAt) start = 1'b1;
        end
        start = 1'b0;
        checkOutput("first_valid_cycle", firstValid, expFirst);
        checkOutput("done_cycle", doneAt, expDone);
        @(negedge clk);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("done_width", int'(done), 0);
        rd_ready = 1'b1;
    endtask

    // Every cycle a beat is valid it must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", 1, 0);
            end else begin
                checkOutput("beat_in", int'(rd_in), int'(expQ[0].inV));
                checkOutput("beat_hip", int'(rd_hip), int'(expQ[0].hipV));
                checkOutput("beat_out", int'(rd_out), int'(expQ[0].outV));
                checkOutput("beat_age", int'(rd_age), int'(expQ[0].age));
                checkOutput("beat_reward", int'(rd_reward), int'(expQ[0].reward));
                checkOutput("beat_last", int'(rd_last), int'(expQ[0].last));
            end
        end
        if (!reset && done) checkOutput("done_after_all_beats", expQ.size(), 0);
    end

    always @(posedge clk) begin
        if (!reset && rd_valid && rd_ready && expQ.size() > 0) void'(expQ.pop_front());
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; rd_ready = 1'b1; reward_sign = 1'b0;
        newest_slot = '0; in_hst = '0; hip_hst = '0; out_hst = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", int'(rd_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_last", int'(rd_last), 0);
        checkOutput("reset_in", int'(rd_in), 0);
        checkOutput("reset_hip", int'(rd_hip), 0);
        checkOutput("reset_age", int'(rd_age), 0);
        reset = 1'b0;

        // Two-slot replay with literal expectations, newest slot 1.
        rd_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'hA5, 8'h3C, 4'b1001);
        @(negedge clk);
        checkOutput("t1_busy_load", int'(busy), 1);
        checkOutput("t1_valid_k1", int'(rd_valid), 0);
        @(negedge clk);
        checkOutput("t1_valid_k2", int'(rd_valid), 1);
        checkOutput("t1_b0_in", int'(rd_in), 'hA);
        checkOutput("t1_b0_hip", int'(rd_hip), 'h3);
        checkOutput("t1_b0_out", int'(rd_out), 2);
        checkOutput("t1_b0_age", int'(rd_age), 0);
        checkOutput("t1_b0_last", int'(rd_last), 0);
        checkOutput("t1_b0_reward", int'(rd_reward), 1);
        @(negedge clk);
        checkOutput("t1_valid_k3", int'(rd_valid), 0);
        @(negedge clk);
        checkOutput("t1_valid_k4", int'(rd_valid), 1);
        checkOutput("t1_b1_in", int'(rd_in), 'h5);
        checkOutput("t1_b1_hip", int'(rd_hip), 'hC);
        checkOutput("t1_b1_out", int'(rd_out), 1);
        checkOutput("t1_b1_age", int'(rd_age), 1);
        checkOutput("t1_b1_last", int'(rd_last), 1);
        @(negedge clk);
        checkOutput("t1_done_k5", int'(done), 0);
        checkOutput("t1_busy_k5", int'(busy), 1);
        @(negedge clk);
        checkOutput("t1_done_k6", int'(done), 1);
        @(negedge clk);
        checkOutput("t1_done_k7", int'(done), 0);

        // Newest slot 0, with a start pulse during FINISH that must be ignored.
        applyStimulus(1'b0, 1'b0, 8'hA5, 8'h3C, 4'b1001);
        runReplay(2, 6, 0, 5);

        // Newest slot 0 empty: skipped, single beat from slot 1 at age 1.
        applyStimulus(1'b0, 1'b1, 8'hA5, 8'h30, 4'b0100);
        runReplay(3, 5, 0, 0);

        // Older slot empty: the newest beat must already carry rd_last.
        applyStimulus(1'b1, 1'b0, 8'hA5, 8'h30, 4'b1000);
        runReplay(2, 4, 0, 0);

        // All-empty snapshot: no beats, done NHIST+2 cycles after start.
        applyStimulus(1'b1, 1'b1, 8'hA5, 8'h00, 4'b0000);
        runReplay(-1, 4, 0, 0);

        // Backpressure for 5 cycles with input changes and repeated start while busy.
        applyStimulus(1'b1, 1'b1, 8'hA5, 8'h3C, 4'b1001);
        runReplay(2, 11, 5, 0);

        // Reset in PRESENT aborts without done, then a fresh replay works.
        rd_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'hA5, 8'h3C, 4'b1001);
        repeat (2) @(negedge clk);
        checkOutput("t6_pre_valid", int'(rd_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_valid", int'(rd_valid), 0);
        checkOutput("t6_busy", int'(busy), 0);
        checkOutput("t6_done", int'(done), 0);
        checkOutput("t6_in", int'(rd_in), 0);
        reset = 1'b0;
        expQ.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t6_no_done", int'(done), 0);
            checkOutput("t6_idle", int'(busy), 0);
        end
        rd_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h5A, 8'hC3, 4'b0110);
        runReplay(2, 6, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
